// File: rtl/ddr_cmd_issuer_pkg.sv
// Shared types and constants for the DDR4 command issuer.
//   parsed_op_t      : request opcode delivered by the request queue
//   dram_cmd_t       : DDR4 command encoding presented to the DIMM model
//   issuer_state_t   : issuer FSM states
//   address field positions, bank count, row/column widths
package ddr_cmd_issuer_pkg;

  localparam int ADDRESS_WIDTH = 33;
  localparam int NUM_BANKS     = 16;
  localparam int ROW_WIDTH     = 15;
  localparam int COL_WIDTH     = 11;

  // Physical address map: row | col_hi | bank | bg | col_lo | byte offset
  localparam int ROW_MSB    = 32;
  localparam int ROW_LSB    = 18;
  localparam int COL_HI_MSB = 17;
  localparam int COL_HI_LSB = 10;
  localparam int BANK_MSB   = 9;
  localparam int BANK_LSB   = 8;
  localparam int BG_MSB     = 7;
  localparam int BG_LSB     = 6;
  localparam int COL_LO_MSB = 5;
  localparam int COL_LO_LSB = 3;

  typedef enum logic [1:0] {
    DATA_READ         = 2'd0,
    DATA_WRITE        = 2'd1,
    INSTRUCTION_FETCH = 2'd2
  } parsed_op_t;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_PRE = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4
  } dram_cmd_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    PRE_WAIT  = 3'd2,
    ACT_WAIT  = 3'd3,
    RW_WAIT   = 3'd4,
    DATA_WAIT = 3'd5
  } issuer_state_t;

endpackage

// File: rtl/ddr_cmd_issuer_bank_state_table.sv
// Per-bank open-page state: {open, row, cycles since ACT}.
//   CPU_clk, rst_n          : clock, async active-low reset (all banks closed)
//   wr_en/wr_act/wr_idx/... : update on ACT (wr_act=1, stores row) or PRE
//   rd_idx/rd_row           : combinational lookup of one bank
//   rd_open/rd_row_match    : bank open, and open on rd_row
//   rd_ras_ok               : a PRE issued this cycle honours tRAS
//   open_flags              : open bit of every bank, index {bg,bank}
module bank_state_table
  import ddr_cmd_issuer_pkg::*;
#(
  parameter int T_RAS = 104
) (
  input  logic                 CPU_clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_act,
  input  logic [3:0]           wr_idx,
  input  logic [ROW_WIDTH-1:0] wr_row,
  input  logic [3:0]           rd_idx,
  input  logic [ROW_WIDTH-1:0] rd_row,
  output logic                 rd_open,
  output logic                 rd_row_match,
  output logic                 rd_ras_ok,
  output logic [NUM_BANKS-1:0] open_flags
);

  // The counter reads 0 in the cycle after ACT, so a PRE in cycle x is legal
  // once the counter reaches T_RAS-1 (x - ACT >= T_RAS).
  localparam logic [7:0] RAS_MIN = 8'(T_RAS - 1);

  logic [NUM_BANKS-1:0] open_q;
  logic [7:0]           ras_q [NUM_BANKS];
  logic [ROW_WIDTH-1:0] row_q [NUM_BANKS];

  always_ff @(posedge CPU_clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) ras_q[i] <= 8'hFF;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (ras_q[i] != 8'hFF) ras_q[i] <= ras_q[i] + 8'd1;
      end
      if (wr_en) begin
        open_q[wr_idx] <= wr_act;
        if (wr_act) ras_q[wr_idx] <= 8'd0;
      end
    end
  end

  // Row storage is only meaningful while the open bit is set.
  always_ff @(posedge CPU_clk) begin
    if (wr_en && wr_act) row_q[wr_idx] <= wr_row;
  end

  assign rd_open      = open_q[rd_idx];
  assign rd_row_match = (row_q[rd_idx] == rd_row);
  assign rd_ras_ok    = (ras_q[rd_idx] >= RAS_MIN);
  assign open_flags   = open_q;

endmodule

// File: rtl/ddr_cmd_issuer.sv
// DDR4 command issuer: accepts one request at a time, decodes the address,
// and emits PRE/ACT/RD/WR with open-page policy and tRCD/tRP/tRAS/CL/CWL
// timing, then pulses done at end of the data burst.
//   CPU_clk, rst_n                      : clock, async active-low reset
//   req_valid/req_ready                 : request handshake (ready only in IDLE)
//   req_opcode, req_address             : request
//   cmd_valid, cmd, cmd_bank_group,
//   cmd_bank, cmd_row, cmd_column       : command strobe and fields
//   done                                : one-cycle completion strobe
//   busy_bank_open                      : per-bank open flags
module ddr_cmd_issuer
  import ddr_cmd_issuer_pkg::*;
#(
  parameter int T_RCD   = 48,
  parameter int T_RP    = 48,
  parameter int T_CL    = 48,
  parameter int T_CWL   = 40,
  parameter int T_RAS   = 104,
  parameter int T_BURST = 8
) (
  input  logic                     CPU_clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  parsed_op_t               req_opcode,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  output logic                     cmd_valid,
  output dram_cmd_t                cmd,
  output logic [1:0]               cmd_bank_group,
  output logic [1:0]               cmd_bank,
  output logic [ROW_WIDTH-1:0]     cmd_row,
  output logic [COL_WIDTH-1:0]     cmd_column,
  output logic                     done,
  output logic [NUM_BANKS-1:0]     busy_bank_open
);

  if (T_RCD < 1 || T_RCD > 255 || T_RP < 1 || T_RP > 255 ||
      T_CL < 1 || T_CL > 255 || T_CWL < 1 || T_CWL > 255 ||
      T_RAS < 1 || T_RAS > 255 || T_BURST < 1 || T_BURST > 255) begin : g_param_check
    $fatal(1, "ddr_cmd_issuer: timing parameters must be in 1..255");
  end

  // A wait of T cycles is loaded as T-1 and ends when the counter hits 0.
  localparam logic [8:0] RCD_DLY = 9'(T_RCD - 1);
  localparam logic [8:0] RP_DLY  = 9'(T_RP - 1);
  localparam logic [8:0] RD_LAT  = 9'(T_CL + T_BURST - 1);
  localparam logic [8:0] WR_LAT  = 9'(T_CWL + T_BURST - 1);

  issuer_state_t        state_q, state_d;
  logic [8:0]           cnt_q, cnt_d;
  dram_cmd_t            cmd_d;
  dram_cmd_t            rw_cmd;
  logic [8:0]           rw_lat;

  logic                 is_wr_q;
  logic [1:0]           bg_q, bank_q;
  logic [ROW_WIDTH-1:0] row_q;
  logic [COL_WIDTH-1:0] col_q;

  logic                 tbl_open, tbl_row_match, tbl_ras_ok;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^req_address[2:0];
  assign req_ready        = (state_q == IDLE);

  // Request latch: data only, meaningful while a request is in flight.
  always_ff @(posedge CPU_clk) begin
    if (req_valid && req_ready) begin
      is_wr_q <= (req_opcode == DATA_WRITE);
      row_q   <= req_address[ROW_MSB:ROW_LSB];
      col_q   <= {req_address[COL_HI_MSB:COL_HI_LSB], req_address[COL_LO_MSB:COL_LO_LSB]};
      bank_q  <= req_address[BANK_MSB:BANK_LSB];
      bg_q    <= req_address[BG_MSB:BG_LSB];
    end
  end

  bank_state_table #(
    .T_RAS(T_RAS)
  ) u_bank_table (
    .CPU_clk     (CPU_clk),
    .rst_n       (rst_n),
    .wr_en       ((cmd_d == CMD_ACT) || (cmd_d == CMD_PRE)),
    .wr_act      (cmd_d == CMD_ACT),
    .wr_idx      ({bg_q, bank_q}),
    .wr_row      (row_q),
    .rd_idx      ({bg_q, bank_q}),
    .rd_row      (row_q),
    .rd_open     (tbl_open),
    .rd_row_match(tbl_row_match),
    .rd_ras_ok   (tbl_ras_ok),
    .open_flags  (busy_bank_open)
  );

  always_ff @(posedge CPU_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = CMD_NOP;
    done    = 1'b0;
    rw_cmd  = is_wr_q ? CMD_WR : CMD_RD;
    rw_lat  = is_wr_q ? WR_LAT : RD_LAT;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (tbl_open && tbl_row_match) begin
          cmd_d   = rw_cmd;
          cnt_d   = rw_lat;
          state_d = DATA_WAIT;
        end else if (!tbl_open) begin
          cmd_d   = CMD_ACT;
          cnt_d   = RCD_DLY;
          state_d = RW_WAIT;
        end else if (tbl_ras_ok) begin
          cmd_d   = CMD_PRE;
          cnt_d   = RP_DLY;
          state_d = ACT_WAIT;
        end else begin
          state_d = PRE_WAIT;
        end
      end
      // Row conflict, holding the PRE until tRAS of the open row has elapsed.
      PRE_WAIT: begin
        if (tbl_ras_ok) begin
          cmd_d   = CMD_PRE;
          cnt_d   = RP_DLY;
          state_d = ACT_WAIT;
        end
      end
      ACT_WAIT: begin
        if (cnt_q == 9'd0) begin
          cmd_d   = CMD_ACT;
          cnt_d   = RCD_DLY;
          state_d = RW_WAIT;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      RW_WAIT: begin
        if (cnt_q == 9'd0) begin
          cmd_d   = rw_cmd;
          cnt_d   = rw_lat;
          state_d = DATA_WAIT;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      DATA_WAIT: begin
        if (cnt_q == 9'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd            = cmd_d;
  assign cmd_valid      = (cmd_d != CMD_NOP);
  assign cmd_bank_group = cmd_valid ? bg_q : 2'd0;
  assign cmd_bank       = cmd_valid ? bank_q : 2'd0;
  assign cmd_row        = (cmd_d == CMD_ACT) ? row_q : '0;
  assign cmd_column     = ((cmd_d == CMD_RD) || (cmd_d == CMD_WR)) ? col_q : '0;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Directed bench for ddr_cmd_issuer. Cycle numbers are relative to the
// accepting posedge (cycle 0); an event "at cycle c" is observed on the
// negedge just before posedge c.
module tb_ddr_cmd_issuer;
  import ddr_cmd_issuer_pkg::*;

  logic                     CPU_clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     req_valid = 1'b0;
  logic                     req_ready;
  parsed_op_t               req_opcode = DATA_READ;
  logic [ADDRESS_WIDTH-1:0] req_address = '0;
  logic                     cmd_valid;
  dram_cmd_t                cmd;
  logic [1:0]               cmd_bank_group;
  logic [1:0]               cmd_bank;
  logic [ROW_WIDTH-1:0]     cmd_row;
  logic [COL_WIDTH-1:0]     cmd_column;
  logic                     done;
  logic [NUM_BANKS-1:0]     busy_bank_open;

  int edge_cnt = 0;
  int nvec = 0;
  int nmis = 0;
  int nop_viol = 0;

  typedef struct {
    int cyc;
    int c;
    int bg;
    int bk;
    int row;
    int col;
  } ev_t;
  ev_t evq[$];
  int  done_q[$];

  ddr_cmd_issuer dut (
    .CPU_clk       (CPU_clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_opcode    (req_opcode),
    .req_address   (req_address),
    .cmd_valid     (cmd_valid),
    .cmd           (cmd),
    .cmd_bank_group(cmd_bank_group),
    .cmd_bank      (cmd_bank),
    .cmd_row       (cmd_row),
    .cmd_column    (cmd_column),
    .done          (done),
    .busy_bank_open(busy_bank_open)
  );

  always #5 CPU_clk = ~CPU_clk;

  always @(posedge CPU_clk) edge_cnt <= edge_cnt + 1;

  always @(negedge CPU_clk) begin
    if (cmd_valid)
      evq.push_back('{cyc: edge_cnt + 1, c: int'(cmd), bg: int'(cmd_bank_group),
                      bk: int'(cmd_bank), row: int'(cmd_row), col: int'(cmd_column)});
    else if (cmd != CMD_NOP)
      nop_viol++;
    if (done) done_q.push_back(edge_cnt + 1);
  end

  task automatic chk(input string tag, input int got, input int want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic exp_ev(input string tag, input int idx, input int cyc, input dram_cmd_t c,
                        input int bk_idx, input int row, input int col);
    if (idx >= evq.size()) begin
      chk({tag, "_missing"}, evq.size(), idx + 1);
    end else begin
      chk({tag, "_cyc"}, evq[idx].cyc, cyc);
      chk({tag, "_cmd"}, evq[idx].c, int'(c));
      chk({tag, "_bank"}, evq[idx].bg * 4 + evq[idx].bk, bk_idx);
      chk({tag, "_row"}, evq[idx].row, row);
      chk({tag, "_col"}, evq[idx].col, col);
    end
  endtask

  task automatic exp_done(input string tag, input int idx, input int cyc);
    if (idx >= done_q.size()) chk({tag, "_missing"}, done_q.size(), idx + 1);
    else chk(tag, done_q[idx], cyc);
  endtask

  task automatic issue(input parsed_op_t op, input logic [ADDRESS_WIDTH-1:0] addr,
                       output int acc);
    int n;
    n = 0;
    @(negedge CPU_clk);
    req_opcode  = op;
    req_address = addr;
    req_valid   = 1'b1;
    while (!req_ready && n < 400) begin
      @(negedge CPU_clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", int'(req_ready), 1);
    acc = edge_cnt + 1;
    @(posedge CPU_clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_q.size() < n && k < budget) begin
      @(posedge CPU_clk);
      k++;
    end
    if (done_q.size() < n) chk("done_timeout", done_q.size(), n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(req_ready), 1);
    chk({tag, "_cmd"}, int'({cmd_valid, cmd, done}), 0);
    chk({tag, "_fields"}, int'({cmd_bank_group, cmd_bank, cmd_row, cmd_column}), 0);
    chk({tag, "_open"}, int'(busy_bank_open), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, d;

    // Reset state
    #3;
    chk_reset_outputs("rst");
    repeat (3) @(negedge CPU_clk);
    rst_n = 1'b1;

    // Read to closed bank 0 row 1, with a second request (row 1 col 1) held
    // pending throughout; it must only be accepted in cycle 106.
    evq.delete();
    done_q.delete();
    @(negedge CPU_clk);
    req_opcode  = DATA_READ;
    req_address = 33'h0_0004_0000;
    req_valid   = 1'b1;
    a = edge_cnt + 1;
    @(posedge CPU_clk);
    #1 req_address = 33'h0_0004_0008;
    d = 0;
    do begin
      @(negedge CPU_clk);
      d++;
    end while (!req_ready && d < 300);
    b = edge_cnt + 1;
    chk("held_accept_cyc", b - a, 106);
    @(posedge CPU_clk);
    #1 req_valid = 1'b0;
    wait_done(2, 200);
    exp_ev("rd1_act", 0, a + 1, CMD_ACT, 0, 1, 0);
    exp_ev("rd1_rd", 1, a + 49, CMD_RD, 0, 0, 0);
    exp_done("rd1_done", 0, a + 105);
    exp_ev("hit_rd", 2, b + 1, CMD_RD, 0, 0, 1);
    exp_done("hit_done", 1, b + 57);
    chk("hit_cmd_count", evq.size(), 3);
    chk("open_after_rd1", int'(busy_bank_open), 16'h0001);

    // Instruction fetch on the open row behaves as a read
    evq.delete();
    done_q.delete();
    issue(INSTRUCTION_FETCH, 33'h0_0004_0000, d);
    wait_done(1, 200);
    exp_ev("ifetch_rd", 0, d + 1, CMD_RD, 0, 0, 0);
    exp_done("ifetch_done", 0, d + 57);

    // Write to closed bank 1, then a read to another row of bank 1: PRE is
    // held back by tRAS to ACT+104.
    evq.delete();
    done_q.delete();
    issue(DATA_WRITE, 33'h0_0004_0100, a);
    wait_done(1, 200);
    issue(DATA_READ, 33'h0_0008_0100, b);
    chk("wr_then_rd_gap", b - a, 98);
    wait_done(2, 400);
    exp_ev("wr_act", 0, a + 1, CMD_ACT, 1, 1, 0);
    exp_ev("wr_wr", 1, a + 49, CMD_WR, 1, 0, 0);
    exp_done("wr_done", 0, a + 97);
    exp_ev("cf_pre", 2, a + 105, CMD_PRE, 1, 0, 0);
    exp_ev("cf_act", 3, a + 153, CMD_ACT, 1, 2, 0);
    exp_ev("cf_rd", 4, a + 201, CMD_RD, 1, 0, 0);
    exp_done("cf_done", 1, a + 257);
    chk("open_after_cf", int'(busy_bank_open), 16'h0003);

    // Conflict on bank 0 long after its ACT: PRE goes out in cycle 1
    evq.delete();
    done_q.delete();
    issue(DATA_READ, 33'h0_0008_0000, d);
    wait_done(1, 300);
    exp_ev("cf0_pre", 0, d + 1, CMD_PRE, 0, 0, 0);
    exp_ev("cf0_act", 1, d + 49, CMD_ACT, 0, 2, 0);
    exp_ev("cf0_rd", 2, d + 97, CMD_RD, 0, 0, 0);
    exp_done("cf0_done", 0, d + 153);

    // Reset to close all banks, then abort a read mid-sequence at cycle 30
    @(negedge CPU_clk);
    rst_n = 1'b0;
    @(negedge CPU_clk);
    chk("rst_mid_open", int'(busy_bank_open), 0);
    rst_n = 1'b1;
    evq.delete();
    done_q.delete();
    issue(DATA_READ, 33'h0_0004_0000, a);
    while (edge_cnt < a + 29) @(negedge CPU_clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    repeat (3) @(negedge CPU_clk);
    rst_n = 1'b1;
    repeat (120) @(posedge CPU_clk);
    exp_ev("abort_act", 0, a + 1, CMD_ACT, 0, 1, 0);
    chk("abort_cmd_count", evq.size(), 1);
    chk("abort_no_done", done_q.size(), 0);

    // Re-issue after abort: the bank is closed again, so ACT first
    evq.delete();
    done_q.delete();
    issue(DATA_READ, 33'h0_0004_0000, b);
    wait_done(1, 200);
    exp_ev("reiss_act", 0, b + 1, CMD_ACT, 0, 1, 0);
    exp_ev("reiss_rd", 1, b + 49, CMD_RD, 0, 0, 0);
    exp_done("reiss_done", 0, b + 105);

    chk("nop_while_invalid", nop_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
